rob_wb_arbiter: RTL and testbench

Shares the ROB's two completion-write ports among NUM_SRC execution units (default ALU1, ALU2, LSU, BRU = sources 0..3). Each source hands over completion records (ROB index, mispredict flag, corrected PC) through a valid/ready handshake into a one-entry holding slot. A round-robin arbiter grants up to two held records per cycle onto registered ROB write ports. The block sits between the execution units and the ROB's Instr_Valid/Mispredicted_Branch/Correct_Branch_Addr update logic.

---
 rtl/rob_wb_arbiter.sv | 149 ++++++++++++++
 tb/tb_rob_wb_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rob_wb_arbiter.sv
// ROB completion write-back arbiter.
// Each execution unit deposits completion records into a one-entry slot;
// a round-robin scan grants up to two full slots per cycle onto two
// registered ROB write ports.
module rob_wb_arbiter #(
  parameter int NUM_SRC        = 4,
  parameter int ROB_INDEX_SIZE = 7,
  parameter int PC_SIZE        = 16
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic                              Flush,
  input  logic                              WB_Stall,
  input  logic [NUM_SRC-1:0]                Src_V,
  output logic [NUM_SRC-1:0]                Src_Ready,
  input  logic [NUM_SRC*ROB_INDEX_SIZE-1:0] Src_Index,
  input  logic [NUM_SRC-1:0]                Src_Mispred,
  input  logic [NUM_SRC*PC_SIZE-1:0]        Src_New_PC,
  output logic                              WB1_V,
  output logic [ROB_INDEX_SIZE-1:0]         WB1_Index,
  output logic                              WB1_Mispred,
  output logic [PC_SIZE-1:0]                WB1_New_PC,
  output logic                              WB2_V,
  output logic [ROB_INDEX_SIZE-1:0]         WB2_Index,
  output logic                              WB2_Mispred,
  output logic [PC_SIZE-1:0]                WB2_New_PC,
  output logic [3:0]                        Pending_Cnt
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]        slot_full;
  logic [NUM_SRC-1:0]        slot_full_next;
  logic [ROB_INDEX_SIZE-1:0] slot_index   [NUM_SRC];
  logic                      slot_mispred [NUM_SRC];
  logic [PC_SIZE-1:0]        slot_pc      [NUM_SRC];

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   rr_ptr_next;
  logic [NUM_SRC-1:0] granted;
  logic [NUM_SRC-1:0] accepted;
  logic               g1_found;
  logic               g2_found;
  logic [PTR_W-1:0]   g1_sel;
  logic [PTR_W-1:0]   g2_sel;
  logic [3:0]         cnt_next;

  // Readiness is forced low during reset; a slot being drained this cycle can be refilled.
  assign Src_Ready = RST_N ? ({NUM_SRC{!Flush}} & (~slot_full | granted)) : '0;
  assign accepted  = Src_V & Src_Ready;
  assign slot_full_next = (slot_full & ~granted) | accepted;

  // Round-robin scan from rr_ptr: first full slot to port 1, second to port 2.
  always_comb begin
    int s;
    int last;
    granted     = '0;
    g1_found    = 1'b0;
    g2_found    = 1'b0;
    g1_sel      = '0;
    g2_sel      = '0;
    rr_ptr_next = rr_ptr;
    s           = 0;
    last        = 0;
    if (!WB_Stall && !Flush) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        s = int'(rr_ptr) + i;
        if (s >= NUM_SRC) s = s - NUM_SRC;
        if (slot_full[s] && !g2_found) begin
          granted[s] = 1'b1;
          last       = s;
          if (!g1_found) begin
            g1_found = 1'b1;
            g1_sel   = s[PTR_W-1:0];
          end else begin
            g2_found = 1'b1;
            g2_sel   = s[PTR_W-1:0];
          end
        end
      end
      if (g1_found) begin
        rr_ptr_next = (last == NUM_SRC - 1) ? '0 : PTR_W'(last + 1);
      end
    end
  end

  // Occupancy after the coming edge; a flush empties everything.
  always_comb begin
    cnt_next = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cnt_next = cnt_next + {3'b000, slot_full_next[k]};
    end
    if (Flush) cnt_next = '0;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_slot
      // Slot capture on accept, release on grant, wipe on flush.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          slot_full[gi]    <= 1'b0;
          slot_index[gi]   <= '0;
          slot_mispred[gi] <= 1'b0;
          slot_pc[gi]      <= '0;
        end else begin
          slot_full[gi] <= Flush ? 1'b0 : slot_full_next[gi];
          if (accepted[gi]) begin
            slot_index[gi]   <= Src_Index[gi*ROB_INDEX_SIZE +: ROB_INDEX_SIZE];
            slot_mispred[gi] <= Src_Mispred[gi];
            slot_pc[gi]      <= Src_New_PC[gi*PC_SIZE +: PC_SIZE];
          end
        end
      end
    end
  endgenerate

  // Write ports pulse valid for one cycle per granted record; data holds otherwise.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rr_ptr      <= '0;
      Pending_Cnt <= '0;
      WB1_V       <= 1'b0;
      WB1_Index   <= '0;
      WB1_Mispred <= 1'b0;
      WB1_New_PC  <= '0;
      WB2_V       <= 1'b0;
      WB2_Index   <= '0;
      WB2_Mispred <= 1'b0;
      WB2_New_PC  <= '0;
    end else begin
      rr_ptr      <= rr_ptr_next;
      Pending_Cnt <= cnt_next;
      WB1_V       <= g1_found;
      WB2_V       <= g2_found;
      if (g1_found) begin
        WB1_Index   <= slot_index[g1_sel];
        WB1_Mispred <= slot_mispred[g1_sel];
        WB1_New_PC  <= slot_pc[g1_sel];
      end
      if (g2_found) begin
        WB2_Index   <= slot_index[g2_sel];
        WB2_Mispred <= slot_mispred[g2_sel];
        WB2_New_PC  <= slot_pc[g2_sel];
      end
    end
  end

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Directed bench for rob_wb_arbiter: expected write-back records are queued
// as stimulus is driven and popped as the write ports fire.
module tb_rob_wb_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        Flush;
  logic        WB_Stall;
  logic [3:0]  Src_V;
  logic [3:0]  Src_Ready;
  logic [27:0] Src_Index;
  logic [3:0]  Src_Mispred;
  logic [63:0] Src_New_PC;
  logic        WB1_V, WB2_V;
  logic [6:0]  WB1_Index, WB2_Index;
  logic        WB1_Mispred, WB2_Mispred;
  logic [15:0] WB1_New_PC, WB2_New_PC;
  logic [3:0]  Pending_Cnt;

  int compared = 0;
  int mismatched = 0;
  logic [23:0] exp_q[$];

  rob_wb_arbiter dut (
    .CLK(CLK), .RST_N(RST_N), .Flush(Flush), .WB_Stall(WB_Stall),
    .Src_V(Src_V), .Src_Ready(Src_Ready), .Src_Index(Src_Index),
    .Src_Mispred(Src_Mispred), .Src_New_PC(Src_New_PC),
    .WB1_V(WB1_V), .WB1_Index(WB1_Index), .WB1_Mispred(WB1_Mispred), .WB1_New_PC(WB1_New_PC),
    .WB2_V(WB2_V), .WB2_Index(WB2_Index), .WB2_Mispred(WB2_Mispred), .WB2_New_PC(WB2_New_PC),
    .Pending_Cnt(Pending_Cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Load one source's record fields.
  task automatic set_src(input int k, input logic [6:0] idx, input logic mis, input logic [15:0] pc);
    Src_Index[k*7 +: 7]   = idx;
    Src_Mispred[k]        = mis;
    Src_New_PC[k*16 +: 16] = pc;
  endtask

  task automatic push_exp(input logic [6:0] idx, input logic mis, input logic [15:0] pc);
    exp_q.push_back({idx, mis, pc});
  endtask

  // Check one port against the scoreboard head when it fires.
  task automatic check_port(input string tag, input logic v, input logic [6:0] idx,
                            input logic mis, input logic [15:0] pc);
    logic [23:0] e;
    if (v) begin
      if (exp_q.size() == 0) begin
        chk({tag, "_unexpected"}, {8'h0, idx, mis, pc}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk({tag, "_rec"}, {8'h0, idx, mis, pc}, {8'h0, e});
        $display("wb %s idx=%0d mis=%0b pc=%04h", tag, idx, mis, pc);
      end
    end
  endtask

  task automatic check_wb(input logic e1, input logic e2, input logic [3:0] epend);
    chk("wb1_v", {31'h0, WB1_V}, {31'h0, e1});
    chk("wb2_v", {31'h0, WB2_V}, {31'h0, e2});
    chk("pending", {28'h0, Pending_Cnt}, {28'h0, epend});
    check_port("wb1", WB1_V, WB1_Index, WB1_Mispred, WB1_New_PC);
    check_port("wb2", WB2_V, WB2_Index, WB2_Mispred, WB2_New_PC);
  endtask

  initial begin
    RST_N = 1'b0; Flush = 1'b0; WB_Stall = 1'b0;
    Src_V = '0; Src_Index = '0; Src_Mispred = '0; Src_New_PC = '0;

    // Reset state
    #12;
    chk("rst_ready", {28'h0, Src_Ready}, 32'h0);
    chk("rst_wb1_v", {31'h0, WB1_V}, 32'h0);
    chk("rst_pending", {28'h0, Pending_Cnt}, 32'h0);
    RST_N = 1'b1;
    #1;
    chk("post_rst_ready", {28'h0, Src_Ready}, 32'hF);

    // Single source: src0 idx 5, mispred, pc 0x0040 -> rr_ptr becomes 1
    Src_V = 4'b0001; set_src(0, 7'd5, 1'b1, 16'h0040); push_exp(7'd5, 1'b1, 16'h0040);
    tick(); Src_V = '0;
    check_wb(1'b0, 1'b0, 4'd1);
    tick(); check_wb(1'b1, 1'b0, 4'd0);

    // src3 alone wraps rr_ptr back to 0
    Src_V = 4'b1000; set_src(3, 7'd7, 1'b0, 16'h0077); push_exp(7'd7, 1'b0, 16'h0077);
    tick(); Src_V = '0;
    check_wb(1'b0, 1'b0, 4'd1);
    tick(); check_wb(1'b1, 1'b0, 4'd0);

    // Four sources at once from rr_ptr=0: 10,11 then 12,13
    Src_V = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      set_src(k, 7'(10 + k), k[0], 16'(16'h1000 + k));
      push_exp(7'(10 + k), k[0], 16'(16'h1000 + k));
    end
    tick(); Src_V = '0;
    check_wb(1'b0, 1'b0, 4'd4);
    tick(); check_wb(1'b1, 1'b1, 4'd2);
    tick(); check_wb(1'b1, 1'b1, 4'd0);

    // src0 alone sets rr_ptr=1
    Src_V = 4'b0001; set_src(0, 7'd20, 1'b0, 16'h0200); push_exp(7'd20, 1'b0, 16'h0200);
    tick(); Src_V = '0;
    tick(); check_wb(1'b1, 1'b0, 4'd0);

    // Fairness: src0 and src3 streaming from rr_ptr=1 -> src3 on port 1, src0 on port 2
    Src_V = 4'b1001;
    set_src(0, 7'd30, 1'b0, 16'h3000); set_src(3, 7'd40, 1'b1, 16'h4000);
    push_exp(7'd40, 1'b1, 16'h4000); push_exp(7'd30, 1'b0, 16'h3000);
    tick(); check_wb(1'b0, 1'b0, 4'd2);
    chk("stream_ready", {28'h0, Src_Ready}, 32'hF);
    for (int n = 1; n < 3; n++) begin
      set_src(0, 7'(30 + n), 1'b0, 16'(16'h3000 + n));
      set_src(3, 7'(40 + n), 1'b1, 16'(16'h4000 + n));
      push_exp(7'(40 + n), 1'b1, 16'(16'h4000 + n));
      push_exp(7'(30 + n), 1'b0, 16'(16'h3000 + n));
      tick(); check_wb(1'b1, 1'b1, 4'd2);
    end
    Src_V = '0;
    tick(); check_wb(1'b1, 1'b1, 4'd0);
    tick(); check_wb(1'b0, 1'b0, 4'd0);

    // Stall for 3 cycles with slots 1,2 full (rr_ptr=1)
    WB_Stall = 1'b1; Src_V = 4'b0110;
    set_src(1, 7'd50, 1'b1, 16'h5000); set_src(2, 7'd51, 1'b0, 16'h5100);
    push_exp(7'd50, 1'b1, 16'h5000); push_exp(7'd51, 1'b0, 16'h5100);
    tick(); Src_V = '0;
    check_wb(1'b0, 1'b0, 4'd2);
    chk("stall_ready0", {28'h0, Src_Ready}, 32'h9);
    tick(); check_wb(1'b0, 1'b0, 4'd2);
    chk("stall_ready1", {28'h0, Src_Ready}, 32'h9);
    tick(); check_wb(1'b0, 1'b0, 4'd2);
    WB_Stall = 1'b0;
    tick(); check_wb(1'b1, 1'b1, 4'd0);

    // Flush with 3 full slots and all sources offering; rr_ptr stays 3
    WB_Stall = 1'b1; Src_V = 4'b0111;
    for (int k = 0; k < 3; k++) set_src(k, 7'(60 + k), 1'b0, 16'(16'h6000 + k));
    tick(); check_wb(1'b0, 1'b0, 4'd3);
    WB_Stall = 1'b0; Flush = 1'b1; Src_V = 4'b1111;
    for (int k = 0; k < 4; k++) set_src(k, 7'(70 + k), 1'b1, 16'(16'h7000 + k));
    #1;
    chk("flush_ready", {28'h0, Src_Ready}, 32'h0);
    tick(); Flush = 1'b0; Src_V = '0;
    check_wb(1'b0, 1'b0, 4'd0);
    tick(); check_wb(1'b0, 1'b0, 4'd0);

    // rr_ptr=3 survived the flush: src3 wins port 1 over src0
    Src_V = 4'b1001;
    set_src(0, 7'd81, 1'b0, 16'h8100); set_src(3, 7'd80, 1'b1, 16'h8000);
    push_exp(7'd80, 1'b1, 16'h8000); push_exp(7'd81, 1'b0, 16'h8100);
    tick(); Src_V = '0;
    tick(); check_wb(1'b1, 1'b1, 4'd0);

    // Asynchronous reset mid-cycle with 3 slots held by stall
    WB_Stall = 1'b1; Src_V = 4'b0111;
    for (int k = 0; k < 3; k++) set_src(k, 7'(90 + k), 1'b1, 16'(16'h9000 + k));
    tick(); Src_V = '0;
    check_wb(1'b0, 1'b0, 4'd3);
    #2 RST_N = 1'b0;
    #1;
    chk("arst_ready", {28'h0, Src_Ready}, 32'h0);
    chk("arst_pending", {28'h0, Pending_Cnt}, 32'h0);
    chk("arst_wb1", {8'h0, WB1_V, WB1_Index, WB1_Mispred, WB1_New_PC}, 32'h0);
    chk("arst_wb2", {8'h0, WB2_V, WB2_Index, WB2_Mispred, WB2_New_PC}, 32'h0);
    WB_Stall = 1'b0;
    #1 RST_N = 1'b1;
    #1;
    chk("arst_release_ready", {28'h0, Src_Ready}, 32'hF);
    tick(); check_wb(1'b0, 1'b0, 4'd0);

    chk("queue_empty", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
